// File: rtl/reg_file.sv
// Multi-port register file: RD_PORTS combinational read ports, one synchronous
// write port, optional hardwired-zero register 0. Define REG_FILE_BYPASS_EN for write-to-read forwarding.
module reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            wAddr,
  input  logic [DATA_W-1:0]            wData,
  input  logic [RD_PORTS*ADDR_W-1:0]   rAddr,
  output logic [RD_PORTS*DATA_W-1:0]   rData
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_en;

  // A write to the hardwired zero register is dropped before it reaches storage.
  assign wr_en = we && !((ZERO_REG != 0) && (wAddr == '0));

  always_comb begin
    // NOTE: every array element gets a default before any conditional update,
    // so no path leaves mem_d unassigned and no latch is inferred.
    mem_d = mem_q;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
    end else if (wr_en) begin
      mem_d[wAddr] = wData;
    end
  end

  // NOTE: the storage itself is reset because the block must read all-zero
  // after a single reset edge; non-blocking assignment keeps the register
  // update ordered against every other clocked process.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rAddr[p*ADDR_W +: ADDR_W];

    always_comb begin
      data = mem_q[addr];
`ifdef REG_FILE_BYPASS_EN
      // Forward the in-flight write; reset suppresses it since the write is discarded.
      if (rst && we && (wAddr == addr)) data = wData;
`endif
      // Applied last so address 0 reads zero even before the first reset.
      if ((ZERO_REG != 0) && (addr == '0)) data = '0;
    end

    assign rData[p*DATA_W +: DATA_W] = data;
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: one ZERO_REG=1 instance and one
// ZERO_REG=0 instance share all stimulus.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  wAddr;
  logic [31:0] wData;
  logic [9:0]  rAddr;
  logic [63:0] rData;
  logic [63:0] rData_nz;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .wAddr(wAddr), .wData(wData),
    .rAddr(rAddr), .rData(rData)
  );

  reg_file #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .we(we), .wAddr(wAddr), .wData(wData),
    .rAddr(rAddr), .rData(rData_nz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rAddr = {a1, a0};
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wAddr = a; wData = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; wAddr = '0; wData = '0; rAddr = '0;

    // Address 0 on the zero-register instance reads 0 even before any reset.
    #1;
    check("pre_reset_zero", rData[31:0], 32'h0);

    tick();
    rst = 1'b1;
    rd(5'd4, 5'd20);
    check("reset_p0", rData[31:0], 32'h0);
    check("reset_p1", rData[63:32], 32'h0);

    for (int a = 1; a < 32; a++) wr(5'(a), 32'hA5A5_0000 + 32'(a));
    rd(5'd1, 5'd31);
    check("fill_1", rData[31:0], 32'hA5A5_0001);
    check("fill_31", rData[63:32], 32'hA5A5_001F);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      check($sformatf("clr_p0_a%0d", a), rData[31:0], 32'h0);
      check($sformatf("clr_p1_a%0d", 31 - a), rData[63:32], 32'h0);
      check($sformatf("clr_nz_a%0d", a), rData_nz[31:0], 32'h0);
    end

    wr(5'd7, 32'hDEAD_BEEF);
    wr(5'd31, 32'h1234_5678);
    rd(5'd7, 5'd31);
    check("wr_p0_7", rData[31:0], 32'hDEAD_BEEF);
    check("wr_p1_31", rData[63:32], 32'h1234_5678);
    rd(5'd7, 5'd7);
    check("same_p0_7", rData[31:0], 32'hDEAD_BEEF);
    check("same_p1_7", rData[63:32], 32'hDEAD_BEEF);

    wr(5'd0, 32'hFFFF_FFFF);
    rd(5'd0, 5'd0);
    check("zero_p0", rData[31:0], 32'h0);
    check("zero_p1", rData[63:32], 32'h0);
    check("nz_p0", rData_nz[31:0], 32'hFFFF_FFFF);

    wr(5'd3, 32'h11);
    we = 1'b0; wAddr = 5'd3; wData = 32'h22;
    rd(5'd3, 5'd3);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("gate_e%0d", k), rData[31:0], 32'h11);
    end

    wr(5'd5, 32'hAAAA);
    rd(5'd5, 5'd3);
    check("rdw_old", rData[31:0], 32'hAAAA);
    we = 1'b1; wAddr = 5'd5; wData = 32'hBBBB;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("rdw_before", rData[31:0], 32'hBBBB);
`else
    check("rdw_before", rData[31:0], 32'hAAAA);
`endif
    check("rdw_other_port", rData[63:32], 32'h11);
    tick();
    we = 1'b0;
    check("rdw_after", rData[31:0], 32'hBBBB);

    // Same-cycle write to address 0: never forwarded on the zero-register instance.
    we = 1'b1; wAddr = 5'd0; wData = 32'h1357_9BDF;
    rd(5'd0, 5'd0);
    check("zero_bypass", rData[31:0], 32'h0);
`ifdef REG_FILE_BYPASS_EN
    check("nz_bypass", rData_nz[31:0], 32'h1357_9BDF);
`else
    check("nz_bypass", rData_nz[31:0], 32'hFFFF_FFFF);
`endif
    tick();
    we = 1'b0;
    check("nz_b2_after", rData_nz[31:0], 32'h1357_9BDF);

    wr(5'd12, 32'h1);
    wr(5'd12, 32'h2);
    rd(5'd12, 5'd12);
    check("b2b_last_wins", rData[31:0], 32'h2);

    wr(5'd9, 32'h55);
    rd(5'd9, 5'd12);
    check("prio_pre", rData[31:0], 32'h55);
    rst = 1'b0; we = 1'b1; wAddr = 5'd9; wData = 32'h77;
    #1;
    // Reset suppresses forwarding, so the stored value shows until the edge.
    check("prio_during", rData[31:0], 32'h55);
    tick();
    check("prio_after_9", rData[31:0], 32'h0);
    check("prio_after_12", rData[63:32], 32'h0);
    rst = 1'b1;
    wr(5'd9, 32'h77);
    rd(5'd9, 5'd0);
    check("post_reset_wr", rData[31:0], 32'h77);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
